// File: rtl/mcu_control_sequencer_if.sv
// ----------------------------------------------------------------------------
// mcu_control_sequencer_if
// Memory handshake bundle between the control sequencer and the instruction /
// data memories.
//   imem_req  : instruction fetch request, held until imem_ack
//   imem_ack  : instruction word valid on instr_in this cycle
//   instr_in  : fetched 16-bit instruction word
//   dmem_req  : data memory request, held until dmem_ack
//   dmem_we   : 1 = store, 0 = load; meaningful while dmem_req=1
//   dmem_ack  : data access complete
// Modports: master = sequencer side, slave = memory side.
// ----------------------------------------------------------------------------
interface mcu_control_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] instr_in;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  instr_in,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output instr_in,
    output dmem_ack
  );
endinterface

// File: rtl/mcu_control_sequencer.sv
// ----------------------------------------------------------------------------
// mcu_control_sequencer
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 16-bit
// MCU core. Handshakes with instruction and data memory and pulses the
// datapath enables. Opcode 4'hF parks the core in HALT until reset.
//
// Parameters
//   TIMEOUT : cycles to wait for a memory ack before flagging bus_err (>=2)
//   CNT_W   : width of the retired-instruction counter
// Ports
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   run        : permission to start a new fetch
//   bus        : memory handshake bundle (master side)
//   zero_flag  : ALU zero flag, consulted by BEQ in EXEC
//   ir_load, alu_en, reg_we, pc_inc, pc_load : single-cycle datapath pulses
//   halted     : core is parked in HALT
//   bus_err    : sticky, a memory ack timed out
//   illegal_op : sticky, an undefined opcode was executed
//   retired    : retired-instruction count, wraps
//   state_o    : current state encoding for debug
// ----------------------------------------------------------------------------
module mcu_control_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  mcu_control_sequencer_if.master     bus,
  input  logic                        zero_flag,
  output logic                        ir_load,
  output logic                        alu_en,
  output logic                        reg_we,
  output logic                        pc_inc,
  output logic                        pc_load,
  output logic                        halted,
  output logic                        bus_err,
  output logic                        illegal_op,
  output logic [CNT_W-1:0]            retired,
  output logic [2:0]                  state_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_BEQ   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Wait counter holds the number of unacknowledged request cycles already
  // seen; it reaches TIMEOUT-1 at the start of the last cycle an ack may come.
  localparam int              WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [3:0]        opcode;
  logic              imem_req_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic req_active;
  logic ack_sel;
  logic timeout_hit;
  logic retire_now;

  assign bus.imem_req = imem_req_q;
  assign bus.dmem_req = (state == S_MEM);
  assign bus.dmem_we  = (state == S_MEM) && (opcode == OP_STORE);

  assign halted  = (state == S_HALT);
  assign state_o = state;

  // One shared wait counter serves both handshakes: only one is ever open.
  assign req_active  = ((state == S_FETCH) && imem_req_q) || (state == S_MEM);
  assign ack_sel     = (state == S_MEM) ? bus.dmem_ack : bus.imem_ack;
  assign timeout_hit = req_active && !ack_sel && (wait_cnt == WAIT_LAST);
  assign retire_now  = pc_inc || pc_load;

  // Datapath pulses are decoded from the current state; reset suppresses
  // them so nothing fires in the cycle a reset is being taken.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ir_load = 1'b0;
    alu_en  = 1'b0;
    reg_we  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: ir_load = imem_req_q && bus.imem_ack;
        S_EXEC: begin
          case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: alu_en = 1'b1;
            OP_LOAD, OP_STORE: ;
            OP_JMP: pc_load = 1'b1;
            OP_BEQ: begin
              pc_load = zero_flag;
              pc_inc  = !zero_flag;
            end
            default: pc_inc = 1'b1;   // NOP and the undefined opcodes
          endcase
        end
        S_MEM: pc_inc = bus.dmem_ack && (opcode == OP_STORE);
        S_WB: begin
          reg_we = 1'b1;
          pc_inc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      opcode     <= 4'h0;
      imem_req_q <= 1'b0;
      wait_cnt   <= '0;
      bus_err    <= 1'b0;
      illegal_op <= 1'b0;
      retired    <= '0;
    end else begin
      retired <= retired + CNT_W'(retire_now);

      case (state)
        S_FETCH: begin
          if (imem_req_q) begin
            // Once raised, the request stays up regardless of run.
            if (bus.imem_ack) begin
              imem_req_q <= 1'b0;
              opcode     <= bus.instr_in[15:12];
              wait_cnt   <= '0;
              state      <= S_DECODE;
            end else if (timeout_hit) begin
              imem_req_q <= 1'b0;
              wait_cnt   <= '0;
              bus_err    <= 1'b1;
              state      <= S_HALT;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else if (run) begin
            imem_req_q <= 1'b1;
          end
        end

        S_DECODE: state <= (opcode == OP_HALT) ? S_HALT : S_EXEC;

        S_EXEC: begin
          case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state <= S_WB;
            OP_LOAD, OP_STORE: state <= S_MEM;
            4'hC, 4'hD, 4'hE: begin
              illegal_op <= 1'b1;
              state      <= S_FETCH;
            end
            default: state <= S_FETCH;
          endcase
        end

        S_MEM: begin
          if (bus.dmem_ack) begin
            wait_cnt <= '0;
            state    <= (opcode == OP_LOAD) ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            wait_cnt <= '0;
            bus_err  <= 1'b1;
            state    <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;   // unused encodings recover to FETCH
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mcu_control_sequencer
// Drives instructions one at a time with chosen or random memory latencies.
// For each instruction the bench writes down, cycle by cycle, what the
// outputs must be from the instruction-level timing rules (one idle fetch
// cycle, request cycles until ack, decode, execute, optional memory and
// writeback). A negedge process compares every output against that
// expectation; directed sequences add literal checks on pulse timing.
// ----------------------------------------------------------------------------
module tb_mcu_control_sequencer;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             zero_flag;
  logic             ir_load, alu_en, reg_we, pc_inc, pc_load;
  logic             halted, bus_err, illegal_op;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_o;

  mcu_control_sequencer_if bus ();

  mcu_control_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .bus        (bus),
    .zero_flag  (zero_flag),
    .ir_load    (ir_load),
    .alu_en     (alu_en),
    .reg_we     (reg_we),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .halted     (halted),
    .bus_err    (bus_err),
    .illegal_op (illegal_op),
    .retired    (retired),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        imem_req, dmem_req, dmem_we;
    logic        ir_load, alu_en, reg_we, pc_inc, pc_load;
    logic        halted, bus_err, illegal_op;
    logic [15:0] retired;
    logic [2:0]  state;
  } exp_t;

  exp_t        e;
  bit          exp_valid = 1'b0;
  bit          zf_pin    = 1'b0;
  logic [15:0] model_retired;
  bit          model_bus_err, model_illegal;
  int          cyc_no;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Observations of the DUT used by the directed literal checks.
  int mon_ir_cyc, mon_alu_cyc, mon_wb_cyc;
  int n_imem_req, n_dmem_req, n_dmem_we, n_reg_we, n_pc_inc, n_pc_load;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc_no);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("imem_req",   bus.imem_req, e.imem_req);
      check("dmem_req",   bus.dmem_req, e.dmem_req);
      if (e.dmem_req) check("dmem_we", bus.dmem_we, e.dmem_we);
      check("ir_load",    ir_load,      e.ir_load);
      check("alu_en",     alu_en,       e.alu_en);
      check("reg_we",     reg_we,       e.reg_we);
      check("pc_inc",     pc_inc,       e.pc_inc);
      check("pc_load",    pc_load,      e.pc_load);
      check("halted",     halted,       e.halted);
      check("bus_err",    bus_err,      e.bus_err);
      check("illegal_op", illegal_op,   e.illegal_op);
      check("retired",    retired,      e.retired);
      check("state_o",    state_o,      e.state);
      if (ir_load)      mon_ir_cyc  = cyc_no;
      if (alu_en)       mon_alu_cyc = cyc_no;
      if (reg_we)       begin mon_wb_cyc = cyc_no; n_reg_we++; end
      if (bus.imem_req) n_imem_req++;
      if (bus.dmem_req) n_dmem_req++;
      if (bus.dmem_req && bus.dmem_we) n_dmem_we++;
      if (pc_inc)       n_pc_inc++;
      if (pc_load)      n_pc_load++;
    end
  end

  task automatic clr_mon();
    mon_ir_cyc = -1; mon_alu_cyc = -1; mon_wb_cyc = -1;
    n_imem_req = 0; n_dmem_req = 0; n_dmem_we = 0;
    n_reg_we = 0; n_pc_inc = 0; n_pc_load = 0;
  endtask

  // Start a fresh expectation for one cycle in the given phase.
  task automatic set_exp(input logic [2:0] st);
    e.imem_req = 0; e.dmem_req = 0; e.dmem_we = 0;
    e.ir_load = 0; e.alu_en = 0; e.reg_we = 0; e.pc_inc = 0; e.pc_load = 0;
    e.state = st;
  endtask

  // Complete the expectation, let one clock cycle elapse, then account for
  // whatever retired in it.
  task automatic cyc();
    e.retired    = model_retired;
    e.bus_err    = model_bus_err;
    e.illegal_op = model_illegal;
    e.halted     = (e.state == 3'd5);
    if (!zf_pin) zero_flag = 1'($urandom);
    exp_valid = !rst;
    @(posedge clk); #1;
    if (e.pc_inc || e.pc_load) model_retired++;
    cyc_no++;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.instr_in = 16'($urandom);
    zf_pin = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; run = 1'b0; exp_valid = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_retired = '0; model_bus_err = 0; model_illegal = 0;
    cyc_no = 0;
  endtask

  task automatic halt_cycles(input int n);
    repeat (n) begin
      set_exp(3'd5);
      run = 1'($urandom);
      cyc();
    end
  endtask

  // One instruction from its first fetch cycle to its retirement.
  //   ilat/dlat : unacknowledged request cycles before the ack (>=TIMEOUT
  //               means the ack never comes)
  //   abort_mem : memory-phase cycle at which reset is applied (-1 = never)
  //   parked    : the core ended up in HALT
  task automatic do_instr(input logic [15:0] instr, input int idle, input int ilat,
                          input int dlat, input bit zf, input int abort_mem,
                          output bit parked);
    logic [3:0] op;
    bit         acked;
    op     = instr[15:12];
    parked = 1'b0;

    repeat (idle) begin run = 1'b0; set_exp(3'd0); cyc(); end
    run = 1'b1; set_exp(3'd0); cyc();

    acked = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      set_exp(3'd0);
      e.imem_req = 1'b1;
      if (k > 0) run = 1'($urandom);
      if (k == ilat) begin
        bus.imem_ack = 1'b1; bus.instr_in = instr; e.ir_load = 1'b1;
        cyc(); acked = 1'b1;
        break;
      end
      cyc();
    end
    if (!acked) begin model_bus_err = 1; parked = 1'b1; return; end

    set_exp(3'd1); cyc();
    if (op == 4'hF) begin parked = 1'b1; return; end

    set_exp(3'd2);
    if (op >= 4'h1 && op <= 4'h7) begin
      e.alu_en = 1'b1; cyc();
      set_exp(3'd4); e.reg_we = 1'b1; e.pc_inc = 1'b1; cyc();
    end else if (op == 4'h8 || op == 4'h9) begin
      cyc();
      acked = 1'b0;
      for (int k = 0; k < TIMEOUT; k++) begin
        set_exp(3'd3);
        e.dmem_req = 1'b1;
        e.dmem_we  = (op == 4'h9);
        if (k == abort_mem) begin do_reset(1); return; end
        if (k == dlat) begin
          bus.dmem_ack = 1'b1;
          if (op == 4'h9) e.pc_inc = 1'b1;
          cyc(); acked = 1'b1;
          break;
        end
        cyc();
      end
      if (!acked) begin model_bus_err = 1; parked = 1'b1; return; end
      if (op == 4'h8) begin
        set_exp(3'd4); e.reg_we = 1'b1; e.pc_inc = 1'b1; cyc();
      end
    end else if (op == 4'hA) begin
      e.pc_load = 1'b1; cyc();
    end else if (op == 4'hB) begin
      zero_flag = zf; zf_pin = 1'b1;
      if (zf) e.pc_load = 1'b1; else e.pc_inc = 1'b1;
      cyc();
    end else begin
      e.pc_inc = 1'b1; cyc();
      if (op >= 4'hC) model_illegal = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          parked;
    logic [15:0] instr;
    int          ilat, dlat, abort;

    rst = 1'b1; run = 1'b0; zero_flag = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.instr_in = 16'h0;
    set_exp(3'd0);
    model_retired = '0; model_bus_err = 0; model_illegal = 0;
    cyc_no = 0;
    @(posedge clk); #1;

    // 1: ALU instruction with immediate acks.
    do_reset(2); clr_mon();
    check("reset_state", state_o, 3'd0);
    check("reset_retired", retired, 0);
    do_instr(16'h1234, 0, 0, 0, 1'b0, -1, parked);
    check("t1_ir_load_cycle", mon_ir_cyc, 1);
    check("t1_alu_en_cycle", mon_alu_cyc, 3);
    check("t1_reg_we_cycle", mon_wb_cyc, 4);
    check("t1_retired", retired, 1);

    // 2: LOAD with the data ack three cycles late.
    clr_mon();
    do_instr(16'h8010, 0, 0, 3, 1'b0, -1, parked);
    check("t2_dmem_req_cycles", n_dmem_req, 4);
    check("t2_dmem_we_cycles", n_dmem_we, 0);
    check("t2_reg_we_count", n_reg_we, 1);
    check("t2_retired", retired, 2);

    // 3: BEQ taken, then not taken.
    clr_mon();
    do_instr(16'hB005, 0, 0, 0, 1'b1, -1, parked);
    check("t3_taken_pc_load", n_pc_load, 1);
    check("t3_taken_pc_inc", n_pc_inc, 0);
    clr_mon();
    do_instr(16'hB005, 0, 0, 0, 1'b0, -1, parked);
    check("t3_fall_pc_load", n_pc_load, 0);
    check("t3_fall_pc_inc", n_pc_inc, 1);

    // 4: HALT parks the core until reset.
    do_instr(16'hF000, 0, 0, 0, 1'b0, -1, parked);
    check("t4_parked_halted", halted, 1);
    clr_mon();
    halt_cycles(20);
    check("t4_no_imem_req", n_imem_req, 0);
    check("t4_retired_held", retired, 4);
    do_reset(1);
    check("t4_rst_clears_halted", halted, 0);

    // 5: instruction ack never arrives, then arrives on the last allowed cycle.
    clr_mon();
    do_instr(16'h1234, 0, TIMEOUT, 0, 1'b0, -1, parked);
    check("t5_req_cycles", n_imem_req, 16);
    check("t5_bus_err", bus_err, 1);
    check("t5_halted", halted, 1);
    halt_cycles(3);
    do_reset(1); clr_mon();
    do_instr(16'h1234, 0, TIMEOUT - 1, 0, 1'b0, -1, parked);
    check("t5_late_req_cycles", n_imem_req, 16);
    check("t5_late_no_err", bus_err, 0);
    check("t5_late_retired", retired, 1);

    // 6: reset in the middle of a data access, then an undefined opcode.
    do_instr(16'h8010, 0, 0, 10, 1'b0, 2, parked);
    clr_mon();
    do_instr(16'hC000, 0, 0, 0, 1'b0, -1, parked);
    check("t6_illegal_op", illegal_op, 1);
    check("t6_pc_inc", n_pc_inc, 1);
    check("t6_retired", retired, 1);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      instr = 16'($urandom);
      ilat  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      dlat  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      abort = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1;
      do_instr(instr, $urandom_range(0, 2), ilat, dlat, 1'($urandom), abort, parked);
      if (parked) begin
        halt_cycles($urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end
    end

    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
